if_fetch: RTL

Instruction-fetch stage of the five-stage MIPS core: owns the PC, issues requests to instruction memory, and presents each fetched word with its return address (PC+4) on the IF side of the IF/ID pipeline register. It is the producer end of that register's interface: it obeys the same `stall` the register obeys and redirects on taken branches and jumps. Whenever no valid instruction is available, it emits an all-zero bubble, which is `sll $0,$0,0`.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_fetch.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: bubble encoding, PC step
// and the fetch-stage state type.
package mips_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    // REQ: request in flight for pc; HOLD: stalled word buffered;
    // DROP: waiting out a request made stale by a redirect.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request
// port and presents each fetched word with PC+4 to the IF/ID register.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_ra,
    output logic [31:0] IF_ins,
    output logic        IF_busy
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ins_buf_q, ins_buf_d;
    logic [31:0]  drop_addr_q, drop_addr_d;

    logic [31:0]  pc_inc;
    logic         ins_valid;
    logic [31:0]  ins_data;
    logic         present;
    logic         outstanding;
    logic         unused_rpc_lo;

    // Wraps modulo 2^32; IF_ra shares this sum.
    assign pc_inc        = pc_q + PC_INC;
    assign unused_rpc_lo = ^redirect_pc[1:0];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        ins_valid = 1'b0;
        ins_data  = NOP;
        imem_req  = 1'b1;
        imem_addr = pc_q;
        unique case (state_q)
            REQ: begin
                ins_valid = imem_ready;
                ins_data  = imem_rdata;
            end
            HOLD: begin
                ins_valid = 1'b1;
                ins_data  = ins_buf_q;
                imem_req  = 1'b0;
            end
            DROP: begin
                imem_addr = drop_addr_q;
            end
            default: begin
                ins_valid = 1'b0;
            end
        endcase
    end

    // The redirect cycle is always a bubble, even when a word is available.
    assign present     = ins_valid && !redirect;
    assign IF_ins      = present ? ins_data : NOP;
    assign IF_ra       = present ? pc_inc : 32'h0;
    assign IF_busy     = !present;
    assign outstanding = imem_req && !imem_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_buf_d   = ins_buf_q;
        drop_addr_d = drop_addr_q;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            if (outstanding) begin
                // The first stale address must be waited out, not a later one.
                if (state_q != DROP) begin
                    drop_addr_d = imem_addr;
                end
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_ready) begin
                        if (stall) begin
                            ins_buf_d = imem_rdata;
                            state_d   = HOLD;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_d    = pc_inc;
                        state_d = REQ;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = REQ;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            ins_buf_q   <= NOP;
            drop_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_buf_q   <= ins_buf_d;
            drop_addr_q <= drop_addr_d;
        end
    end

endmodule
